// File: rtl/syscall_unit.sv
// MIPS syscall service unit: stalls the core while print_int/print_char/print_string
// run, streams characters/integers to stdout, and latches exit into a sticky halt.
module syscall_unit #(
  parameter int unsigned MAX_STR = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        syscall,
  input  logic [31:0] sys_call_reg,
  input  logic [31:0] std_out_address,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        out_valid,
  output logic        out_kind,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        halted,
  output logic        err
);

  localparam int unsigned CW = $clog2(MAX_STR + 1);

  typedef enum logic [2:0] {IDLE, EMIT, STR_REQ, STR_EMIT, HALTED} state_t;

  state_t        state, state_d;
  logic [31:0]   addr;
  logic          int_kind;
  logic [7:0]    chr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_inc;
  logic [7:0]    sel_byte;
  logic          latch, load_chr, advance, set_err, set_halt;

  assign count_inc = count + CW'(1);

  // Big-endian byte lane within the fetched word.
  always_comb begin
    case (addr[1:0])
      2'd0:    sel_byte = mem_rdata[31:24];
      2'd1:    sel_byte = mem_rdata[23:16];
      2'd2:    sel_byte = mem_rdata[15:8];
      default: sel_byte = mem_rdata[7:0];
    endcase
  end

  always_comb begin
    state_d   = state;
    latch     = 1'b0;
    load_chr  = 1'b0;
    advance   = 1'b0;
    set_err   = 1'b0;
    set_halt  = 1'b0;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    out_valid = 1'b0;
    out_kind  = 1'b0;
    out_data  = '0;
    case (state)
      IDLE: begin
        if (syscall) begin
          stall = 1'b1;
          latch = 1'b1;
          case (sys_call_reg)
            32'd1, 32'd11: state_d = EMIT;
            32'd4:         state_d = STR_REQ;
            32'd10: begin
              state_d  = HALTED;
              set_halt = 1'b1;
            end
            default:       set_err = 1'b1;
          endcase
        end
      end
      EMIT: begin
        stall     = 1'b1;
        out_valid = 1'b1;
        out_kind  = int_kind;
        out_data  = int_kind ? addr : {24'b0, addr[7:0]};
        if (out_ready) state_d = IDLE;
      end
      STR_REQ: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {addr[31:2], 2'b00};
        if (mem_ack) begin
          if (sel_byte == 8'h00) begin
            state_d = IDLE;
          end else begin
            load_chr = 1'b1;
            state_d  = STR_EMIT;
          end
        end
      end
      STR_EMIT: begin
        stall     = 1'b1;
        out_valid = 1'b1;
        out_data  = {24'b0, chr};
        if (out_ready) begin
          advance = 1'b1;
          if (count_inc == CW'(MAX_STR)) begin
            set_err = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = STR_REQ;
          end
        end
      end
      HALTED:  stall = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr     <= '0;
      int_kind <= 1'b0;
      chr      <= '0;
      count    <= '0;
      halted   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_d;
      if (latch) begin
        addr     <= std_out_address;
        int_kind <= (sys_call_reg == 32'd1);
        count    <= '0;
      end
      if (load_chr) chr <= sel_byte;
      if (advance) begin
        addr  <= addr + 32'd1;
        count <= count_inc;
      end
      if (set_err)  err    <= 1'b1;
      if (set_halt) halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_syscall_unit.sv
// Scoreboard bench for syscall_unit: directed syscalls push expected stdout items,
// a negedge monitor pops and compares on every accepted transfer.
module tb_syscall_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        syscall;
  logic [31:0] sys_call_reg;
  logic [31:0] std_out_address;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        out_valid;
  logic        out_kind;
  logic [31:0] out_data;
  logic        out_ready;
  logic        halted;
  logic        err;

  int passed = 0;
  int total  = 0;
  int xfers  = 0;

  logic [32:0] exp_q [$];
  logic [31:0] addr_log [$];
  logic [31:0] mem [0:63];

  syscall_unit #(.MAX_STR(4)) dut (
    .clk(clk), .rst_n(rst_n), .syscall(syscall), .sys_call_reg(sys_call_reg),
    .std_out_address(std_out_address), .stall(stall), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .out_valid(out_valid), .out_kind(out_kind), .out_data(out_data),
    .out_ready(out_ready), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compare every accepted item, and verify hold under backpressure.
  initial begin
    logic        prev_hold;
    logic [32:0] prev_item;
    logic [32:0] e;
    prev_hold = 1'b0;
    prev_item = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_item", {out_kind, out_data}, prev_item);
        end
        if (out_valid && out_ready) begin
          xfers++;
          if (exp_q.size() == 0) begin
            chk("unexpected_out", out_valid, 0);
          end else begin
            e = exp_q.pop_front();
            chk("out_item", {out_kind, out_data}, e);
          end
        end
        prev_hold = out_valid && !out_ready;
        prev_item = {out_kind, out_data};
      end
    end
  end

  // Memory responder: random 0-4 cycle ack latency, logs each served address.
  initial begin
    int unsigned wait_cnt;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    wait_cnt  = $urandom_range(0, 4);
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (mem_req) begin
        if (wait_cnt == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr[7:2]];
          addr_log.push_back(mem_addr);
          wait_cnt  = $urandom_range(0, 4);
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // Issue one syscall, then count stall cycles (syscall cycle included) up to budget.
  task automatic run_syscall(input logic [31:0] v0, input logic [31:0] a0,
                             input int budget, output int n);
    @(posedge clk);
    #1;
    syscall = 1'b1;
    sys_call_reg = v0;
    std_out_address = a0;
    n = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
      @(posedge clk);
      #1;
      syscall = 1'b0;
    end
    syscall = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  task automatic push_chr(input logic [7:0] c);
    exp_q.push_back({1'b0, 24'b0, c});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit got;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0] = 32'h0048690A;                 // 0x1000
    mem[1] = 32'h00000000;                 // 0x1004
    mem[4] = 32'h41424344;                 // 0x1010
    mem[5] = 32'h45464748;
    mem[6] = 32'h494A0000;
    mem[8] = 32'h41424300;                 // 0x1020
    rst_n = 1'b0;
    syscall = 1'b0;
    sys_call_reg = '0;
    std_out_address = '0;
    out_ready = 1'b1;

    #3;
    chk("rst_stall", stall, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_kind", out_kind, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // print_char
    exp_q.push_back({1'b0, 32'h00000041});
    run_syscall(32'd11, 32'h00000141, 50, n);
    chk("pchar_stall_cycles", n, 2);
    drain("pchar_drain");

    // print_int with 3 cycles of backpressure
    out_ready = 1'b0;
    exp_q.push_back({1'b1, 32'hFFFFFFFB});
    fork
      run_syscall(32'd1, 32'hFFFFFFFB, 50, n);
      begin
        got = 0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (out_valid) begin got = 1; break; end
        end
        chk("pint_valid_seen", got, 1);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    chk("pint_stall_cycles", n, 5);
    chk("pint_xfers", xfers, 2);
    drain("pint_drain");

    // unaligned print_string
    addr_log.delete();
    push_chr(8'h48); push_chr(8'h69); push_chr(8'h0A);
    run_syscall(32'd4, 32'h00001001, 400, n);
    drain("ustr_drain");
    chk("ustr_reads", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      chk("ustr_addr0", addr_log[0], 32'h1000);
      chk("ustr_addr1", addr_log[1], 32'h1000);
      chk("ustr_addr2", addr_log[2], 32'h1000);
      chk("ustr_addr3", addr_log[3], 32'h1004);
    end
    chk("ustr_err", err, 0);

    // MAX_STR overflow: 10-byte string truncated to 4
    push_chr(8'h41); push_chr(8'h42); push_chr(8'h43); push_chr(8'h44);
    run_syscall(32'd4, 32'h00001010, 400, n);
    drain("maxstr_drain");
    chk("maxstr_err", err, 1);
    chk("maxstr_idle", stall, 0);

    // exit, then ignored syscall while halted
    run_syscall(32'd10, 32'h0, 10, n);
    chk("exit_stall_cycles", n, 10);
    chk("exit_halted", halted, 1);
    chk("exit_err_kept", err, 1);
    run_syscall(32'd11, 32'h41, 5, n);
    chk("halt_stall_cycles", n, 5);
    drain("halt_drain");
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    chk("halt_rst_halted", halted, 0);
    chk("halt_rst_err", err, 0);
    chk("halt_rst_stall", stall, 0);
    chk("halt_rst_valid", out_valid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // reset mid-string after two characters
    push_chr(8'h41); push_chr(8'h42);
    fork
      run_syscall(32'd4, 32'h00001020, 400, n);
      begin
        int base;
        base = xfers;
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (xfers == base + 2) break;
        end
        chk("mid_two_chars", xfers - base, 2);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_mem_req", mem_req, 0);
        chk("mid_rst_stall", stall, 0);
      end
    join
    @(posedge clk);
    #1 rst_n = 1'b1;
    drain("mid_drain");

    // unsupported code
    run_syscall(32'd99, 32'h0, 20, n);
    chk("bad_stall_cycles", n, 1);
    chk("bad_err", err, 1);
    chk("bad_halted", halted, 0);
    drain("bad_drain");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
